// File: rtl/qlearn_pkg.sv
// Shared Q-learning constants and types for the FrozenLake Q-table and its update datapath.
package qlearn_pkg;

   localparam int unsigned N_STATES  = 16;
   localparam int unsigned N_ACTIONS = 4;
   localparam int unsigned DW        = 16;
   localparam int unsigned SW        = $clog2(N_STATES);
   localparam int unsigned AW        = $clog2(N_ACTIONS);
   localparam int unsigned EW        = SW + AW;
   localparam int unsigned ENTRIES   = N_STATES * N_ACTIONS;

   localparam logic [DW-1:0] Q_ONE = 16'h0100;

   typedef enum logic [AW-1:0] {A_LEFT, A_DOWN, A_RIGHT, A_UP} action_e;

   typedef enum logic [1:0] {StIdle, StScan, StOut} fetch_state_e;

endpackage

// File: rtl/qtable_regfile.sv
// Register-based Q-table: one write port, two combinational read ports with write-first bypass.
module qtable_regfile
   import qlearn_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          we_i,
   input  logic [EW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [EW-1:0] raddr_old_i,
   output logic [DW-1:0] rdata_old_o,
   input  logic [EW-1:0] raddr_scan_i,
   output logic [DW-1:0] rdata_scan_o
);

   logic [DW-1:0] mem_q [ENTRIES];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // A same-cycle write to the addressed entry wins over the stored value.
   assign rdata_old_o  = (we_i && (waddr_i == raddr_old_i))  ? wdata_i : mem_q[raddr_old_i];
   assign rdata_scan_o = (we_i && (waddr_i == raddr_scan_i)) ? wdata_i : mem_q[raddr_scan_i];

endmodule

// File: rtl/qtable_max_fetch.sv
// Q-table operand stage: fetches Q(s,a) and max/argmax over row s', then presents the bundle
// to the update datapath; write-back commits new values into the table.
module qtable_max_fetch
   import qlearn_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          req_valid_i,
   output logic          req_ready_o,
   input  logic [SW-1:0] req_state_i,
   input  logic [AW-1:0] req_action_i,
   input  logic [SW-1:0] req_next_state_i,
   input  logic [DW-1:0] req_reward_i,
   input  logic          req_terminal_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [DW-1:0] old_value_o,
   output logic [DW-1:0] reward_o,
   output logic [DW-1:0] next_max_o,
   output logic [AW-1:0] next_argmax_o,
   output logic [SW-1:0] out_state_o,
   output logic [AW-1:0] out_action_o,
   input  logic          wb_valid_i,
   input  logic [SW-1:0] wb_state_i,
   input  logic [AW-1:0] wb_action_i,
   input  logic [DW-1:0] wb_value_i
);

   fetch_state_e  state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [SW-1:0] s_q, s_d, ns_q, ns_d;
   logic [AW-1:0] a_q, a_d;
   logic [DW-1:0] reward_q, reward_d;
   logic          term_q, term_d;
   logic [DW-1:0] old_q, old_d;
   logic [DW-1:0] max_q, max_d;
   logic [AW-1:0] argmax_q, argmax_d;
   logic [DW-1:0] rd_old, rd_scan;

   qtable_regfile u_regfile (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .we_i         (wb_valid_i),
      .waddr_i      ({wb_state_i, wb_action_i}),
      .wdata_i      (wb_value_i),
      .raddr_old_i  ({s_q, a_q}),
      .rdata_old_o  (rd_old),
      .raddr_scan_i ({ns_q, idx_q}),
      .rdata_scan_o (rd_scan)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      s_d         = s_q;
      a_d         = a_q;
      ns_d        = ns_q;
      reward_d    = reward_q;
      term_d      = term_q;
      old_d       = old_q;
      max_d       = max_q;
      argmax_d    = argmax_q;
      req_ready_o = 1'b0;
      out_valid_o = 1'b0;
      unique case (state_q)
         StIdle: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               s_d      = req_state_i;
               a_d      = req_action_i;
               ns_d     = req_next_state_i;
               reward_d = req_reward_i;
               term_d   = req_terminal_i;
               idx_d    = '0;
               max_d    = '0;
               argmax_d = '0;
               state_d  = StScan;
            end
         end
         StScan: begin
            if (idx_q == '0) begin
               old_d = rd_old;
            end
            // Max starts at 0 and only a strictly greater value replaces it: ties keep lower idx.
            if (!term_q && (rd_scan > max_q)) begin
               max_d    = rd_scan;
               argmax_d = idx_q;
            end
            // A terminal request spends exactly one cycle here, just to latch old_value.
            if (term_q || (idx_q == AW'(N_ACTIONS - 1))) begin
               state_d = StOut;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StOut: begin
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         s_q      <= '0;
         a_q      <= '0;
         ns_q     <= '0;
         reward_q <= '0;
         term_q   <= 1'b0;
         old_q    <= '0;
         max_q    <= '0;
         argmax_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         s_q      <= s_d;
         a_q      <= a_d;
         ns_q     <= ns_d;
         reward_q <= reward_d;
         term_q   <= term_d;
         old_q    <= old_d;
         max_q    <= max_d;
         argmax_q <= argmax_d;
      end
   end

   assign old_value_o   = old_q;
   assign reward_o      = reward_q;
   assign next_max_o    = max_q;
   assign next_argmax_o = argmax_q;
   assign out_state_o   = s_q;
   assign out_action_o  = a_q;

endmodule

// File: tb/tb_qtable_max_fetch.sv
// Directed self-checking bench for qtable_max_fetch.
module tb_qtable_max_fetch;
   import qlearn_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready;
   logic [SW-1:0] req_state, req_next_state;
   logic [AW-1:0] req_action;
   logic [DW-1:0] req_reward;
   logic          req_terminal;
   logic          out_valid, out_ready;
   logic [DW-1:0] old_value, reward, next_max;
   logic [AW-1:0] next_argmax, out_action;
   logic [SW-1:0] out_state;
   logic          wb_valid;
   logic [SW-1:0] wb_state;
   logic [AW-1:0] wb_action;
   logic [DW-1:0] wb_value;

   int n_checks = 0;
   int n_fail   = 0;
   int lat;
   logic [DW-1:0] hold_old, hold_max;
   logic          seen_valid;

   always #5 clk = ~clk;

   qtable_max_fetch dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .req_valid_i      (req_valid),
      .req_ready_o      (req_ready),
      .req_state_i      (req_state),
      .req_action_i     (req_action),
      .req_next_state_i (req_next_state),
      .req_reward_i     (req_reward),
      .req_terminal_i   (req_terminal),
      .out_valid_o      (out_valid),
      .out_ready_i      (out_ready),
      .old_value_o      (old_value),
      .reward_o         (reward),
      .next_max_o       (next_max),
      .next_argmax_o    (next_argmax),
      .out_state_o      (out_state),
      .out_action_o     (out_action),
      .wb_valid_i       (wb_valid),
      .wb_state_i       (wb_state),
      .wb_action_i      (wb_action),
      .wb_value_i       (wb_value)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wb_write(input logic [SW-1:0] s, input logic [AW-1:0] a,
                           input logic [DW-1:0] v);
      @(negedge clk);
      wb_valid  = 1'b1;
      wb_state  = s;
      wb_action = a;
      wb_value  = v;
      @(negedge clk);
      wb_valid  = 1'b0;
   endtask

   // Issues one request; optionally writes (5,3)=wbv at the wb_at-th negedge after the request.
   // lat is the number of cycles until out_valid is seen (0 on timeout).
   task automatic run_req(input logic [SW-1:0] s, input logic [AW-1:0] a,
                          input logic [SW-1:0] ns, input logic [DW-1:0] r, input logic term,
                          input int wb_at, input logic [DW-1:0] wbv, output int lat_o);
      @(negedge clk);
      check_eq("req_ready_before_req", 32'(req_ready), 32'd1);
      req_valid      = 1'b1;
      req_state      = s;
      req_action     = a;
      req_next_state = ns;
      req_reward     = r;
      req_terminal   = term;
      lat_o = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         wb_valid  = (k == wb_at);
         wb_state  = 4'd5;
         wb_action = 2'd3;
         wb_value  = wbv;
         if (out_valid) begin
            lat_o = k;
            break;
         end
      end
      wb_valid = 1'b0;
   endtask

   task automatic accept();
      out_ready = 1'b1;
      check_eq("req_ready_while_out", 32'(req_ready), 32'd0);
      @(negedge clk);
      out_ready = 1'b0;
      check_eq("req_ready_after_accept", 32'(req_ready), 32'd1);
      check_eq("out_valid_after_accept", 32'(out_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_state = '0; req_action = '0; req_next_state = '0;
      req_reward = '0; req_terminal = 1'b0; out_ready = 1'b0;
      wb_valid = 1'b0; wb_state = '0; wb_action = '0; wb_value = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset state
      check_eq("rst_req_ready", 32'(req_ready), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_old", 32'(old_value), 32'd0);
      check_eq("rst_reward", 32'(reward), 32'd0);
      check_eq("rst_next_max", 32'(next_max), 32'd0);
      check_eq("rst_argmax", 32'(next_argmax), 32'd0);
      check_eq("rst_out_state", 32'(out_state), 32'd0);
      check_eq("rst_out_action", 32'(out_action), 32'd0);

      // 1: empty table
      run_req(4'd0, 2'd2, 4'd1, 16'h0000, 1'b0, 0, 16'h0, lat);
      check_eq("t1_latency", 32'(lat), 32'd5);
      check_eq("t1_old", 32'(old_value), 32'd0);
      check_eq("t1_next_max", 32'(next_max), 32'd0);
      check_eq("t1_argmax", 32'(next_argmax), 32'd0);
      check_eq("t1_out_action", 32'(out_action), 32'd2);
      accept();

      // 2: row 5 with a tie at indices 1 and 2
      wb_write(4'd5, 2'd0, 16'h0040);
      wb_write(4'd5, 2'd1, 16'h0180);
      wb_write(4'd5, 2'd2, 16'h0180);
      wb_write(4'd5, 2'd3, Q_ONE);
      wb_write(4'd3, 2'd1, 16'h0123);
      run_req(4'd3, 2'd1, 4'd5, 16'h0020, 1'b0, 0, 16'h0, lat);
      check_eq("t2_latency", 32'(lat), 32'd5);
      check_eq("t2_next_max", 32'(next_max), 32'h0180);
      check_eq("t2_argmax", 32'(next_argmax), 32'd1);
      check_eq("t2_old", 32'(old_value), 32'h0123);
      check_eq("t2_reward", 32'(reward), 32'h0020);
      check_eq("t2_out_state", 32'(out_state), 32'd3);
      check_eq("t2_out_action", 32'(out_action), 32'd1);

      // 4: backpressure holds the bundle
      hold_old = old_value;
      hold_max = next_max;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_eq("t4_out_valid_held", 32'(out_valid), 32'd1);
         check_eq("t4_req_ready_low", 32'(req_ready), 32'd0);
         check_eq("t4_old_stable", 32'(old_value), 32'(hold_old));
         check_eq("t4_max_stable", 32'(next_max), 32'(hold_max));
      end
      accept();

      // 3: terminal next state
      run_req(4'd3, 2'd1, 4'd5, Q_ONE, 1'b1, 0, 16'h0, lat);
      check_eq("t3_latency", 32'(lat), 32'd2);
      check_eq("t3_next_max", 32'(next_max), 32'd0);
      check_eq("t3_argmax", 32'(next_argmax), 32'd0);
      check_eq("t3_reward", 32'(reward), 32'h0100);
      check_eq("t3_old", 32'(old_value), 32'h0123);
      accept();

      // 5a: write-back of (5,3) in the idx=3 scan cycle is bypassed
      run_req(4'd0, 2'd0, 4'd5, 16'h0, 1'b0, 4, 16'h0200, lat);
      check_eq("t5a_latency", 32'(lat), 32'd5);
      check_eq("t5a_next_max", 32'(next_max), 32'h0200);
      check_eq("t5a_argmax", 32'(next_argmax), 32'd3);
      accept();
      wb_write(4'd5, 2'd3, Q_ONE);

      // 5b: same write at idx=1 lands before entry 3 is scanned
      run_req(4'd0, 2'd0, 4'd5, 16'h0, 1'b0, 2, 16'h0200, lat);
      check_eq("t5b_next_max", 32'(next_max), 32'h0200);
      check_eq("t5b_argmax", 32'(next_argmax), 32'd3);
      accept();

      // Table now holds (5,3)=0x0200
      run_req(4'd5, 2'd3, 4'd0, 16'h0, 1'b0, 0, 16'h0, lat);
      check_eq("t5c_old", 32'(old_value), 32'h0200);
      accept();

      // 6: reset during SCAN
      @(negedge clk);
      req_valid = 1'b1; req_state = 4'd5; req_action = 2'd3; req_next_state = 4'd5;
      req_reward = 16'h0055; req_terminal = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("t6_out_valid", 32'(out_valid), 32'd0);
      check_eq("t6_req_ready", 32'(req_ready), 32'd1);
      check_eq("t6_reward", 32'(reward), 32'd0);
      seen_valid = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen_valid = 1'b1;
      end
      check_eq("t6_no_bundle", 32'(seen_valid), 32'd0);
      run_req(4'd5, 2'd3, 4'd5, 16'h0007, 1'b0, 0, 16'h0, lat);
      check_eq("t6_latency", 32'(lat), 32'd5);
      check_eq("t6_old_cleared", 32'(old_value), 32'd0);
      check_eq("t6_max_cleared", 32'(next_max), 32'd0);
      check_eq("t6_argmax", 32'(next_argmax), 32'd0);
      check_eq("t6_reward_new", 32'(reward), 32'h0007);
      accept();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
